// File: rtl/rmii_tx_framer.sv
`timescale 1ns/1ps
// RMII transmit framer: wraps an upstream dibit stream with preamble/SFD,
// zero-pads short payloads, appends the CRC-32 FCS and enforces the
// inter-frame gap. One dibit per 50 MHz reference clock.
module rmii_tx_framer #(
  parameter bit PAD_EN     = 1'b1,
  parameter int MIN_DIBITS = 240,
  parameter int IFG_DIBITS = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_axi_valid,
  input  logic [1:0] tx_axi_data,
  output logic       tx_axi_ready,
  output logic [1:0] rmii_txd,
  output logic       rmii_txen,
  output logic       tx_busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam logic [12:0] CNT_MAX  = 13'h1FFF;
  localparam logic [12:0] MIN_CNT  = 13'(MIN_DIBITS);
  localparam logic [12:0] IFG_LAST = 13'(IFG_DIBITS - 1);
  localparam logic [12:0] PRE_LAST = 13'd31;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  // Shared counter: preamble index, payload/pad dibit count, FCS index, IFG count.
  logic [12:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic [1:0]  txd_q, txd_d;
  logic        txen_q, txen_d;
  logic        done_q, done_d;
  logic [3:0]  fcs_nxt;

  // Fold one dibit into the reflected CRC-32, bit 0 first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Payload counter saturates so very long frames never wrap.
  function automatic logic [12:0] sat_inc(input logic [12:0] c);
    return (c == CNT_MAX) ? c : c + 13'd1;
  endfunction

  assign fcs_nxt = cnt_q[3:0] + 4'd1;

  // State register and registered pin/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      crc_q   <= 32'hFFFFFFFF;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      txd_q   <= 2'b00;
      txen_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      done_q  <= done_d;
    end
  end

  // Next state plus next values of the registered outputs; the values
  // computed here appear on the pins in the following cycle.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    txd_d   = 2'b00;
    txen_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // First dibit stays parked upstream until the SFD cycle.
        if (tx_axi_valid) begin
          state_d = S_PRE;
          crc_d   = 32'hFFFFFFFF;
          cnt_d   = '0;
        end
      end
      S_PRE: begin
        txen_d = 1'b1;
        if (cnt_q == PRE_LAST) begin
          // SFD goes out with ready high so the first dibit follows it directly.
          txd_d   = 2'b11;
          ready_d = 1'b1;
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          txd_d = 2'b01;
          cnt_d = cnt_q + 13'd1;
        end
      end
      S_DATA: begin
        txen_d = 1'b1;
        if (tx_axi_valid && ready_q) begin
          ready_d = 1'b1;
          txd_d   = tx_axi_data;
          crc_d   = crc_dibit(crc_q, tx_axi_data);
          cnt_d   = sat_inc(cnt_q);
        end else if (PAD_EN && (cnt_q < MIN_CNT)) begin
          state_d = S_PAD;
          txd_d   = 2'b00;
          crc_d   = crc_dibit(crc_q, 2'b00);
          cnt_d   = sat_inc(cnt_q);
        end else begin
          state_d = S_FCS;
          txd_d   = ~crc_q[1:0];
          cnt_d   = '0;
        end
      end
      S_PAD: begin
        txen_d = 1'b1;
        if (cnt_q >= MIN_CNT) begin
          state_d = S_FCS;
          txd_d   = ~crc_q[1:0];
          cnt_d   = '0;
        end else begin
          txd_d = 2'b00;
          crc_d = crc_dibit(crc_q, 2'b00);
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_FCS: begin
        // crc_q is not touched here, so it stays frozen for all 16 dibits.
        if (cnt_q[3:0] == 4'd15) begin
          state_d = S_IFG;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          txen_d = 1'b1;
          txd_d  = ~crc_q[{fcs_nxt, 1'b0} +: 2];
          cnt_d  = cnt_q + 13'd1;
        end
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign tx_axi_ready = ready_q;
  assign rmii_txd     = txd_q;
  assign rmii_txen    = txen_q;
  assign frame_done   = done_q;
  assign tx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rmii_tx_framer.sv
`timescale 1ns/1ps
// Directed bench for rmii_tx_framer: one instance without padding, one with.
module tb_rmii_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] vld, rdy, txen, busy, done;
  logic [1:0] dat0, dat1, txd0, txd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rmii_tx_framer #(.PAD_EN(1'b0), .MIN_DIBITS(240), .IFG_DIBITS(48)) u_a (
    .clk(clk), .rst_n(rst_n),
    .tx_axi_valid(vld[0]), .tx_axi_data(dat0), .tx_axi_ready(rdy[0]),
    .rmii_txd(txd0), .rmii_txen(txen[0]), .tx_busy(busy[0]), .frame_done(done[0])
  );

  rmii_tx_framer #(.PAD_EN(1'b1), .MIN_DIBITS(240), .IFG_DIBITS(48)) u_b (
    .clk(clk), .rst_n(rst_n),
    .tx_axi_valid(vld[1]), .tx_axi_data(dat1), .tx_axi_ready(rdy[1]),
    .rmii_txd(txd1), .rmii_txen(txen[1]), .tx_busy(busy[1]), .frame_done(done[1])
  );

  // Per-frame results filled by run_frame.
  logic [7:0] pay[$];
  logic [1:0] wire_q[$];
  int hi_cnt, xfers, first_x, last_x, pre_low, rdy_lo, first_rdy;
  logic done_end, timed_out, reset_hit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_en(input int sel);
    return (sel == 1) ? txen[1] : txen[0];
  endfunction
  function automatic logic get_rdy(input int sel);
    return (sel == 1) ? rdy[1] : rdy[0];
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 1) ? done[1] : done[0];
  endfunction
  function automatic logic [1:0] get_txd(input int sel);
    return (sel == 1) ? txd1 : txd0;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [1:0] d);
    if (sel == 1) begin vld[1] = v; dat1 = d; end
    else          begin vld[0] = v; dat0 = d; end
  endtask

  // Reference CRC-32 over the payload bytes, zero-extended to pad_to bytes.
  function automatic logic [31:0] crc_model(input int pad_to);
    logic [31:0] c;
    logic [7:0]  b;
    int n;
    c = 32'hFFFFFFFF;
    n = (pay.size() > pad_to) ? pay.size() : pad_to;
    for (int i = 0; i < n; i++) begin
      b = (i < pay.size()) ? pay[i] : 8'h00;
      for (int k = 0; k < 8; k++)
        c = (c[0] ^ b[k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic int pre_bad();
    int bad;
    if (wire_q.size() < 32) return 99;
    bad = 0;
    for (int i = 0; i < 31; i++) if (wire_q[i] !== 2'b01) bad++;
    if (wire_q[31] !== 2'b11) bad++;
    return bad;
  endfunction

  function automatic int payload_bad();
    int bad;
    logic [7:0] b;
    bad = 0;
    if (wire_q.size() < 32 + 4 * pay.size()) return 99999;
    for (int i = 0; i < 4 * pay.size(); i++) begin
      b = pay[i / 4];
      if (wire_q[32 + i] !== b[2 * (i % 4) +: 2]) bad++;
    end
    return bad;
  endfunction

  function automatic logic [31:0] fcs_rx();
    logic [31:0] f;
    int base;
    f = '0;
    if (wire_q.size() < 48) return 32'hDEAD_DEAD;
    base = wire_q.size() - 16;
    for (int i = 0; i < 16; i++) f[2 * i +: 2] = wire_q[base + i];
    return f;
  endfunction

  // Sends pay[] on instance sel and records the wire until txen falls.
  // Entered and left at posedge+1. rst_at>=0 asserts reset once that many
  // dibits have been seen with txen high.
  task automatic run_frame(input int sel, input int budget, input int rst_at);
    logic [1:0] dib[$];
    logic [7:0] b;
    int idx, cyc;
    logic pend, seen_hi, fin;
    dib = {};
    foreach (pay[i]) begin
      b = pay[i];
      for (int k = 0; k < 4; k++) dib.push_back(b[2 * k +: 2]);
    end
    wire_q = {}; hi_cnt = 0; xfers = 0; first_x = -1; last_x = -1;
    pre_low = 0; rdy_lo = 0; first_rdy = -1;
    done_end = 1'b0; timed_out = 1'b0; reset_hit = 1'b0;
    idx = 0; cyc = 0; seen_hi = 1'b0; fin = 1'b0;
    drive(sel, 1'b1, dib[0]);
    pend = get_rdy(sel);
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      if (pend) begin
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        xfers++;
        idx++;
      end
      if (get_en(sel)) begin
        seen_hi = 1'b1;
        wire_q.push_back(get_txd(sel));
        if (get_rdy(sel) && first_rdy < 0) first_rdy = hi_cnt;
        hi_cnt++;
      end else begin
        if (get_rdy(sel)) rdy_lo++;
        if (seen_hi) begin
          fin = 1'b1;
          done_end = get_done(sel);
        end else begin
          pre_low++;
        end
      end
      if (!fin && rst_at >= 0 && hi_cnt == rst_at) begin
        rst_n = 1'b0;
        #2;
        reset_hit = 1'b1;
        fin = 1'b1;
      end
      if (!fin && cyc >= budget) begin
        timed_out = 1'b1;
        fin = 1'b1;
      end
      if (idx < dib.size()) drive(sel, 1'b1, dib[idx]);
      else                  drive(sel, 1'b0, 2'b00);
      pend = (idx < dib.size()) && get_rdy(sel);
    end
  endtask

  task automatic load_digits();
    pay = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  endtask

  initial begin
    rst_n = 1'b0;
    vld = 2'b00; dat0 = 2'b00; dat1 = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txen_a",  32'(txen[0]), 32'd0);
    chk("rst_txd_a",   32'(txd0),    32'd0);
    chk("rst_ready_a", 32'(rdy[0]),  32'd0);
    chk("rst_busy_a",  32'(busy[0]), 32'd0);
    chk("rst_done_a",  32'(done[0]), 32'd0);
    chk("rst_txen_b",  32'(txen[1]), 32'd0);
    chk("rst_busy_b",  32'(busy[1]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // CRC of "123456789", no padding.
    load_digits();
    run_frame(0, 400, -1);
    chk("crc_timeout",  32'(timed_out), 32'd0);
    chk("crc_txen_len", hi_cnt, 32'd84);
    chk("crc_xfers",    xfers, 32'd36);
    chk("crc_preamble", pre_bad(), 32'd0);
    chk("crc_payload",  payload_bad(), 32'd0);
    chk("crc_fcs",      fcs_rx(), 32'hCBF43926);
    chk("crc_fcs_b0",   32'(fcs_rx() & 32'hFF), 32'h26);
    chk("crc_done",     32'(done_end), 32'd1);
    chk("crc_rdy_lo",   rdy_lo, 32'd0);

    // Padding: one byte 0xA5 on the padding instance.
    pay = {8'hA5};
    run_frame(1, 600, -1);
    chk("pad_timeout",  32'(timed_out), 32'd0);
    chk("pad_xfers",    xfers, 32'd4);
    chk("pad_txen_len", hi_cnt, 32'd288);
    if (wire_q.size() >= 288) begin
      int nz;
      chk("pad_data", 32'({wire_q[35], wire_q[34], wire_q[33], wire_q[32]}), 32'b10_10_01_01);
      nz = 0;
      for (int i = 36; i < 272; i++) if (wire_q[i] !== 2'b00) nz++;
      chk("pad_zeros", nz, 32'd0);
    end else begin
      chk("pad_wire_len", wire_q.size(), 32'd288);
    end
    chk("pad_fcs", fcs_rx(), crc_model(60));

    // First dibit 11 must be held upstream and appear right after the SFD.
    repeat (60) @(posedge clk);
    #1;
    pay = {8'h1B};
    run_frame(0, 300, -1);
    chk("ret_first_rdy", first_rdy, 32'd31);
    chk("ret_rdy_lo",    rdy_lo, 32'd0);
    chk("ret_preamble",  pre_bad(), 32'd0);
    chk("ret_first_txd", 32'(wire_q.size() > 32 ? wire_q[32] : 2'bxx), 32'd3);
    chk("ret_txen_len",  hi_cnt, 32'd52);

    // Back-to-back: second frame raised on the frame_done cycle.
    repeat (60) @(posedge clk);
    #1;
    load_digits();
    run_frame(0, 400, -1);
    chk("b2b_done1", 32'(done_end), 32'd1);
    run_frame(0, 400, -1);
    chk("b2b_gap",      pre_low + 1, 32'd50);
    chk("b2b_txen_len", hi_cnt, 32'd84);
    chk("b2b_fcs",      fcs_rx(), 32'hCBF43926);

    // Long frame: 1514 bytes on the padding instance.
    pay = {};
    for (int i = 0; i < 1514; i++) pay.push_back(8'((i * 7 + 3) & 255));
    run_frame(1, 7000, -1);
    chk("long_timeout",  32'(timed_out), 32'd0);
    chk("long_xfers",    xfers, 32'd6056);
    chk("long_span",     last_x - first_x, 32'd6055);
    chk("long_txen_len", hi_cnt, 32'd6104);
    chk("long_payload",  payload_bad(), 32'd0);
    chk("long_fcs",      fcs_rx(), crc_model(0));

    // Reset during FCS dibit 4, then a clean frame after release.
    repeat (60) @(posedge clk);
    #1;
    load_digits();
    run_frame(0, 400, 73);
    chk("arst_hit",   32'(reset_hit), 32'd1);
    chk("arst_txen",  32'(txen[0]), 32'd0);
    chk("arst_txd",   32'(txd0),    32'd0);
    chk("arst_ready", 32'(rdy[0]),  32'd0);
    chk("arst_busy",  32'(busy[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pay = {8'h55};
    run_frame(0, 300, -1);
    chk("arst_preamble", pre_bad(), 32'd0);
    chk("arst_txen_len", hi_cnt, 32'd52);
    chk("arst_payload",  payload_bad(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
